vector_list_builder: RTL and testbench
======================================

VECTOR_LIST_BUILDER -- requirements
Module: vector_list_builder

Interface
REQ-001 SHALL have parameter VECTOR_RAM_WIDTH, default 9, the vector RAM address width in bits.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic runs on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1, command present.
REQ-005 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid && cmd_ready.
REQ-006 SHALL have port cmd_op, input, 2, opcode: 0 BEGIN, 1 POINT, 2 END, 3 CLEAR.
REQ-007 SHALL have port cmd_data, input, 16, operand: BEGIN [7:0] = attributes (colour[7:4], intensity[3:0]); POINT [7:0] = x, [15:8] = y.
REQ-008 SHALL have port ram_addr, output, VECTOR_RAM_WIDTH, the vector RAM write address.
REQ-009 SHALL have port ram_data, output, 8, the vector RAM write data.
REQ-010 SHALL have port ram_write, output, 1, the vector RAM write strobe, one byte per cycle.
REQ-011 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-012 SHALL have port error, output, 1, sticky command-error flag.
REQ-013 SHALL have port in_line, output, 1, high between an accepted BEGIN and its END.

Function
REQ-014 SHALL build a line list in vector RAM with this layout per line: [len][attr][x0][y0][x1][y1]..., with the list terminated by a 0 byte.
REQ-015 SHALL write len = points - 2, because the consumer draws len+1 segments; a line SHALL therefore have 3 to 257 points.
REQ-016 SHALL hold these registers: wr_ptr (next free byte), hdr_ptr (len byte of the open line), and pt_cnt (9 bits).
REQ-017 SHALL use FSM states IDLE, INIT, HDR, ATTR, PX, PY, TERM, LEN and CLR.
REQ-018 SHALL assert cmd_ready only in IDLE; for a command accepted in cycle T, the N writes SHALL occur in cycles T+1 to T+N, and cmd_ready SHALL return high in cycle T+N+1.
REQ-019 SHALL execute BEGIN as HDR then ATTR:
- HDR writes 0 at wr_ptr (keeps the list terminated while the line is built).
- ATTR writes the attributes at wr_ptr+1.
- Then hdr_ptr = wr_ptr, wr_ptr += 2, pt_cnt = 0, in_line = 1.
REQ-020 SHALL execute POINT as PX then PY: x at wr_ptr, y at wr_ptr+1; then wr_ptr += 2 and pt_cnt += 1.
REQ-021 SHALL execute END with pt_cnt >= 3 as TERM then LEN, in this order:
- TERM writes 0 at wr_ptr.
- LEN writes pt_cnt-2 at hdr_ptr.
- Then in_line = 0.
REQ-022 SHALL handle END with pt_cnt < 3 as: discard the line, wr_ptr = hdr_ptr, one TERM write of 0 at hdr_ptr, in_line = 0; error is unchanged.
REQ-023 SHALL execute CLEAR as one CLR write of 0 at address 0; then wr_ptr = 0, in_line = 0, error = 0. CLEAR is legal in any IDLE context.
REQ-024 SHALL treat these as errors: BEGIN while in_line; POINT or END while !in_line; POINT when pt_cnt = 257; BEGIN or POINT when wr_ptr + 2 > 2^VECTOR_RAM_WIDTH - 1, which reserves one terminator byte.
REQ-025 SHALL, on an error, still accept the command (1-cycle handshake, no RAM write), set error, and leave all pointers and the FSM state unchanged.
REQ-026 SHALL perform all pointer arithmetic at VECTOR_RAM_WIDTH bits; the capacity check in REQ-024 SHALL guarantee wr_ptr never wraps.
REQ-027 SHALL drive ram_write, ram_addr and ram_data from registers, and ram_write SHALL be 0 in IDLE.

Reset
REQ-028 SHALL, while reset is high, hold: cmd_ready = 0, ram_write = 0, ram_addr = 0, ram_data = 0, busy = 1, error = 0, in_line = 0, wr_ptr = 0, hdr_ptr = 0, pt_cnt = 0, state = INIT.
REQ-029 SHALL, in INIT after reset release, write 0 at address 0 in one cycle and then enter IDLE.
REQ-030 SHALL, when reset is asserted mid-command, abandon the command; RAM contents beyond address 0 are don't-care after the INIT write.

Structure
REQ-031 SHALL define the opcode constants (OP_BEGIN, OP_POINT, OP_END, OP_CLEAR) and the list-format constants (LEN_BIAS = 2, MAX_POINTS = 257) in a shared vector package, also used by the vector renderer and by CPU-side tests.
REQ-032 SHALL be a single flat module with no sub-module.

Verification
REQ-033 Bench SHALL cover reset release: expect one write (addr 0, data 00), then cmd_ready = 1 on the following cycle.
REQ-034 Bench SHALL cover BEGIN 0x3F; POINT (10,20), (50,20), (50,60); END:
- Expected RAM: 00: 01 3F 0A 14 32 14 32 3C 00.
- TERM at address 8 is written before LEN at address 0.
REQ-035 Bench SHALL cover BEGIN 0x11; POINT (1,1), (2,2); END:
- Expected: wr_ptr returns to 0, addr 0 = 00, error = 0, in_line = 0.
REQ-036 Bench SHALL cover POINT issued with no open line, then BEGIN twice:
- Expected: error = 1 after the first POINT, no RAM writes for the POINT or the second BEGIN.
- CLEAR then clears error and writes 00 at address 0.
REQ-037 Bench SHALL cover a capacity limit with VECTOR_RAM_WIDTH = 4:
- Sequence: BEGIN, then 7 POINTs.
- Expected: only the first 6 POINTs write; the 7th sets error; END writes TERM at address 14 and len 04 at address 0.
REQ-038 Bench SHALL cover reset asserted in cycle PY of a POINT:
- Expected: all outputs are at their reset values immediately, INIT writes 00 at address 0, then IDLE.

Source files
------------

// File: rtl/vector_list_builder_pkg.sv
// Shared vector-list definitions: command opcodes, list-format constants and
// the builder's FSM state encoding.
package vector_list_builder_pkg;

  localparam logic [1:0] OP_BEGIN = 2'd0;
  localparam logic [1:0] OP_POINT = 2'd1;
  localparam logic [1:0] OP_END   = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  // The renderer draws len+1 segments, so len = points - LEN_BIAS.
  localparam logic [8:0] LEN_BIAS   = 9'd2;
  localparam logic [8:0] MAX_POINTS = 9'd257;
  localparam logic [8:0] MIN_POINTS = LEN_BIAS + 9'd1;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    HDR,
    ATTR,
    PX,
    PY,
    TERM,
    LEN,
    CLR
  } vlb_state_e;

endpackage

// File: rtl/vector_list_builder.sv
// Builds a zero-terminated list of vector lines ([len][attr][x][y]...) in an
// external byte-wide RAM from BEGIN/POINT/END/CLEAR commands.
module vector_list_builder
  import vector_list_builder_pkg::*;
#(
  parameter int VECTOR_RAM_WIDTH = 9
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [15:0]                 cmd_data,
  output logic [VECTOR_RAM_WIDTH-1:0] ram_addr,
  output logic [7:0]                  ram_data,
  output logic                        ram_write,
  output logic                        busy,
  output logic                        error,
  output logic                        in_line,
  output vlb_state_e                  fsm_state
);

  localparam int W = VECTOR_RAM_WIDTH;
  // Highest wr_ptr that still leaves room for two bytes plus the terminator.
  localparam logic [W-1:0] PTR_LIMIT = {W{1'b1}} - W'(2);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE and the command operand is latched on transfer.
  vlb_state_e   state, state_nx;
  logic [W-1:0] wr_ptr, wr_ptr_nx;
  logic [W-1:0] hdr_ptr, hdr_ptr_nx;
  logic [8:0]   pt_cnt, pt_cnt_nx;
  logic [15:0]  opnd, opnd_nx;
  logic         error_nx, in_line_nx;
  logic         ram_write_nx;
  logic [W-1:0] ram_addr_nx;
  logic [7:0]   ram_data_nx;

  logic         accept;
  logic         no_room;
  logic [W-1:0] wr_ptr_p1;
  logic [W-1:0] wr_ptr_p2;
  logic [8:0]   len_full;

  assign accept    = cmd_valid && (state == IDLE);
  assign no_room   = wr_ptr > PTR_LIMIT;
  assign wr_ptr_p1 = wr_ptr + W'(1);
  assign wr_ptr_p2 = wr_ptr + W'(2);
  assign len_full  = pt_cnt - LEN_BIAS;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  always_comb begin
    state_nx     = state;
    wr_ptr_nx    = wr_ptr;
    hdr_ptr_nx   = hdr_ptr;
    pt_cnt_nx    = pt_cnt;
    opnd_nx      = opnd;
    error_nx     = error;
    in_line_nx   = in_line;
    ram_write_nx = 1'b0;
    ram_addr_nx  = ram_addr;
    ram_data_nx  = ram_data;

    case (state)
      // First cycle arms the terminator write, second cycle presents it.
      INIT: begin
        if (!ram_write) begin
          ram_write_nx = 1'b1;
          ram_addr_nx  = '0;
          ram_data_nx  = 8'h00;
        end else begin
          state_nx = IDLE;
        end
      end

      IDLE: begin
        if (accept) begin
          opnd_nx = cmd_data;
          case (cmd_op)
            OP_BEGIN: begin
              if (in_line || no_room) begin
                error_nx = 1'b1;
              end else begin
                state_nx     = HDR;
                ram_write_nx = 1'b1;
                ram_addr_nx  = wr_ptr;
                ram_data_nx  = 8'h00;
              end
            end
            OP_POINT: begin
              if (!in_line || (pt_cnt == MAX_POINTS) || no_room) begin
                error_nx = 1'b1;
              end else begin
                state_nx     = PX;
                ram_write_nx = 1'b1;
                ram_addr_nx  = wr_ptr;
                ram_data_nx  = cmd_data[7:0];
              end
            end
            OP_END: begin
              if (!in_line) begin
                error_nx = 1'b1;
              end else begin
                // A too-short line is dropped by terminating the list at its header.
                state_nx     = TERM;
                ram_write_nx = 1'b1;
                ram_addr_nx  = (pt_cnt >= MIN_POINTS) ? wr_ptr : hdr_ptr;
                ram_data_nx  = 8'h00;
              end
            end
            default: begin
              state_nx     = CLR;
              ram_write_nx = 1'b1;
              ram_addr_nx  = '0;
              ram_data_nx  = 8'h00;
            end
          endcase
        end
      end

      HDR: begin
        state_nx     = ATTR;
        ram_write_nx = 1'b1;
        ram_addr_nx  = wr_ptr_p1;
        ram_data_nx  = opnd[7:0];
      end

      ATTR: begin
        state_nx   = IDLE;
        hdr_ptr_nx = wr_ptr;
        wr_ptr_nx  = wr_ptr_p2;
        pt_cnt_nx  = '0;
        in_line_nx = 1'b1;
      end

      PX: begin
        state_nx     = PY;
        ram_write_nx = 1'b1;
        ram_addr_nx  = wr_ptr_p1;
        ram_data_nx  = opnd[15:8];
      end

      PY: begin
        state_nx  = IDLE;
        wr_ptr_nx = wr_ptr_p2;
        pt_cnt_nx = pt_cnt + 9'd1;
      end

      TERM: begin
        if (pt_cnt >= MIN_POINTS) begin
          state_nx     = LEN;
          ram_write_nx = 1'b1;
          ram_addr_nx  = hdr_ptr;
          ram_data_nx  = len_full[7:0];
        end else begin
          state_nx   = IDLE;
          wr_ptr_nx  = hdr_ptr;
          in_line_nx = 1'b0;
        end
      end

      LEN: begin
        state_nx   = IDLE;
        in_line_nx = 1'b0;
      end

      CLR: begin
        state_nx   = IDLE;
        wr_ptr_nx  = '0;
        in_line_nx = 1'b0;
        error_nx   = 1'b0;
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      wr_ptr    <= '0;
      hdr_ptr   <= '0;
      pt_cnt    <= '0;
      opnd      <= '0;
      error     <= 1'b0;
      in_line   <= 1'b0;
      ram_write <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= 8'h00;
    end else begin
      state     <= state_nx;
      wr_ptr    <= wr_ptr_nx;
      hdr_ptr   <= hdr_ptr_nx;
      pt_cnt    <= pt_cnt_nx;
      opnd      <= opnd_nx;
      error     <= error_nx;
      in_line   <= in_line_nx;
      ram_write <= ram_write_nx;
      ram_addr  <= ram_addr_nx;
      ram_data  <= ram_data_nx;
    end
  end

endmodule

// File: tb/tb_vector_list_builder.sv
// Bench for vector_list_builder: a default-width instance (a) and a 4-bit
// address instance (b) share the clock, reset and command operand lines.
module tb_vector_list_builder;
  import vector_list_builder_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;

  logic        cmd_valid_a, cmd_ready_a, ram_write_a, busy_a, error_a, in_line_a;
  logic [8:0]  ram_addr_a;
  logic [7:0]  ram_data_a;
  vlb_state_e  fsm_state_a;

  logic        cmd_valid_b, cmd_ready_b, ram_write_b, busy_b, error_b, in_line_b;
  logic [3:0]  ram_addr_b;
  logic [7:0]  ram_data_b;
  vlb_state_e  fsm_state_b;

  always #5 clk = ~clk;

  vector_list_builder dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .ram_addr(ram_addr_a), .ram_data(ram_data_a),
    .ram_write(ram_write_a), .busy(busy_a), .error(error_a), .in_line(in_line_a),
    .fsm_state(fsm_state_a)
  );

  vector_list_builder #(.VECTOR_RAM_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .ram_addr(ram_addr_b), .ram_data(ram_data_b),
    .ram_write(ram_write_b), .busy(busy_b), .error(error_b), .in_line(in_line_b),
    .fsm_state(fsm_state_b)
  );

  int total = 0;
  int bad = 0;

  // Reference model: one list image and pointer set per instance.
  int          m_wr[2], m_hdr[2], m_pts[2];
  bit          m_in[2], m_err[2];
  int          m_last[2] = '{511, 15};
  logic [7:0]  model_ram[2][512];
  logic [7:0]  bench_ram[2][512];
  int          last_addr[2];
  logic [16:0] exp_a_q[$];
  logic [16:0] exp_b_q[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic logic rdy(input int s);
    return (s == 0) ? cmd_ready_a : cmd_ready_b;
  endfunction

  function automatic logic err(input int s);
    return (s == 0) ? error_a : error_b;
  endfunction

  function automatic logic inl(input int s);
    return (s == 0) ? in_line_a : in_line_b;
  endfunction

  task automatic expect_write(input int s, input int addr, input logic [7:0] data);
    logic [8:0] a9;
    a9 = addr[8:0];
    if (s == 0) exp_a_q.push_back({a9, data});
    else        exp_b_q.push_back({a9, data});
    model_ram[s][a9] = data;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_wr[s] = 0; m_hdr[s] = 0; m_pts[s] = 0; m_in[s] = 0; m_err[s] = 0;
      expect_write(s, 0, 8'h00);
    end
  endtask

  // Expected writes of one command, in order; n = number of writes.
  task automatic model_cmd(input int s, input logic [1:0] op, input logic [15:0] d,
                           output int n);
    n = 0;
    case (op)
      OP_BEGIN: begin
        if (m_in[s] || m_wr[s] + 2 > m_last[s]) m_err[s] = 1;
        else begin
          expect_write(s, m_wr[s], 8'h00);
          expect_write(s, m_wr[s] + 1, d[7:0]);
          n = 2;
          m_hdr[s] = m_wr[s]; m_wr[s] += 2; m_pts[s] = 0; m_in[s] = 1;
        end
      end
      OP_POINT: begin
        if (!m_in[s] || m_pts[s] == MAX_POINTS || m_wr[s] + 2 > m_last[s]) m_err[s] = 1;
        else begin
          expect_write(s, m_wr[s], d[7:0]);
          expect_write(s, m_wr[s] + 1, d[15:8]);
          n = 2;
          m_wr[s] += 2; m_pts[s]++;
        end
      end
      OP_END: begin
        if (!m_in[s]) m_err[s] = 1;
        else begin
          if (m_pts[s] >= 3) begin
            expect_write(s, m_wr[s], 8'h00);
            expect_write(s, m_hdr[s], 8'(m_pts[s] - 2));
            n = 2;
          end else begin
            expect_write(s, m_hdr[s], 8'h00);
            m_wr[s] = m_hdr[s];
            n = 1;
          end
          m_in[s] = 0;
        end
      end
      default: begin
        expect_write(s, 0, 8'h00);
        n = 1;
        m_wr[s] = 0; m_in[s] = 0; m_err[s] = 0;
      end
    endcase
  endtask

  task automatic send(input int s, input logic [1:0] op, input logic [15:0] d);
    int n, cyc;
    model_cmd(s, op, d, n);
    cyc = 0;
    @(negedge clk);
    while (!rdy(s) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 50) begin
      fail_now("cmd_ready_wait");
      return;
    end
    cmd_op = op;
    cmd_data = d;
    if (s == 0) cmd_valid_a = 1'b1;
    else        cmd_valid_b = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid_a = 1'b0;
    cmd_valid_b = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!rdy(s) && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    check("handshake_latency", cyc, n);
    check("error_flag", err(s), m_err[s]);
    check("in_line_flag", inl(s), m_in[s]);
  endtask

  // Monitor: every RAM write must match the next expected write of its instance.
  always @(negedge clk) begin
    if (ram_write_a) begin
      if (exp_a_q.size() == 0) begin
        total++; bad++;
        $display("FAIL write_a: unexpected write addr 0x%0h data 0x%0h", ram_addr_a, ram_data_a);
      end else check("write_a", {ram_addr_a, ram_data_a}, exp_a_q.pop_front());
      bench_ram[0][ram_addr_a] = ram_data_a;
      last_addr[0] = int'(ram_addr_a);
    end
    if (ram_write_b) begin
      if (exp_b_q.size() == 0) begin
        total++; bad++;
        $display("FAIL write_b: unexpected write addr 0x%0h data 0x%0h", ram_addr_b, ram_data_b);
      end else check("write_b", {5'b0, ram_addr_b, ram_data_b}, exp_b_q.pop_front());
      bench_ram[1][9'(ram_addr_b)] = ram_data_b;
      last_addr[1] = int'(ram_addr_b);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp34[9];
    logic [1:0] op;
    int r, mism;
    exp34 = '{8'h01, 8'h3F, 8'h0A, 8'h14, 8'h32, 8'h14, 8'h32, 8'h3C, 8'h00};
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 512; a++) begin
        model_ram[s][a] = 8'h00;
        bench_ram[s][a] = 8'h00;
      end

    // Clock/reset
    reset = 1'b1;
    cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
    cmd_op = OP_BEGIN; cmd_data = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready_a, 0);
    check("rst_ram_write", ram_write_a, 0);
    check("rst_ram_addr", ram_addr_a, 0);
    check("rst_ram_data", ram_data_a, 0);
    check("rst_busy", busy_a, 1);
    check("rst_error", error_a, 0);
    check("rst_in_line", in_line_a, 0);
    check("rst_state", fsm_state_a, INIT);
    model_reset();
    reset = 1'b0;
    @(negedge clk);
    check("init_write_strobe", ram_write_a, 1);
    check("init_write_addr", ram_addr_a, 0);
    check("init_write_data", ram_data_a, 0);
    @(negedge clk);
    check("init_then_ready", cmd_ready_a, 1);
    check("init_then_no_write", ram_write_a, 0);

    // One triangle-free polyline of three points
    send(0, OP_BEGIN, 16'h003F);
    send(0, OP_POINT, {8'd20, 8'd10});
    send(0, OP_POINT, {8'd20, 8'd50});
    send(0, OP_POINT, {8'd60, 8'd50});
    send(0, OP_END, 16'h0000);
    for (int i = 0; i < 9; i++) check("line3_ram", bench_ram[0][i], exp34[i]);
    check("line3_len_last", last_addr[0], 0);

    // Two-point line is discarded
    send(0, OP_CLEAR, 16'h0000);
    send(0, OP_BEGIN, 16'h0011);
    send(0, OP_POINT, {8'd1, 8'd1});
    send(0, OP_POINT, {8'd2, 8'd2});
    send(0, OP_END, 16'h0000);
    check("short_addr0", bench_ram[0][0], 0);
    check("short_error", error_a, 0);
    check("short_in_line", in_line_a, 0);
    send(0, OP_BEGIN, 16'h0022);
    check("short_wr_ptr_back", last_addr[0], 1);

    // Command errors
    send(0, OP_CLEAR, 16'h0000);
    send(0, OP_POINT, 16'h0505);
    check("point_no_line_err", error_a, 1);
    send(0, OP_BEGIN, 16'h0033);
    send(0, OP_BEGIN, 16'h0044);
    check("double_begin_err", error_a, 1);
    send(0, OP_CLEAR, 16'h0000);
    check("clear_err", error_a, 0);
    check("clear_addr0", bench_ram[0][0], 0);

    // Capacity limit on the 16-byte instance
    send(1, OP_BEGIN, 16'h0055);
    for (int k = 0; k < 7; k++) send(1, OP_POINT, {8'(k + 100), 8'(k)});
    check("cap_err", error_b, 1);
    send(1, OP_END, 16'h0000);
    check("cap_term14", bench_ram[1][14], 0);
    check("cap_len", bench_ram[1][0], 4);
    check("cap_last_addr", last_addr[1], 0);

    // Randomized command stream against the model
    send(0, OP_CLEAR, 16'h0000);
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 12)      op = OP_BEGIN;
      else if (r < 80) op = OP_POINT;
      else if (r < 96) op = OP_END;
      else             op = OP_CLEAR;
      send(0, op, 16'($urandom));
    end
    mism = 0;
    for (int a = 0; a < 512; a++)
      if (bench_ram[0][a] !== model_ram[0][a]) mism++;
    check("ram_image_mismatches", mism, 0);

    // Reset during the PY write of a POINT
    send(0, OP_CLEAR, 16'h0000);
    send(0, OP_BEGIN, 16'h0077);
    expect_write(0, m_wr[0], 8'h34);
    r = 0;
    @(negedge clk);
    while (!cmd_ready_a && r < 50) begin
      @(negedge clk);
      r++;
    end
    cmd_op = OP_POINT; cmd_data = 16'h1234; cmd_valid_a = 1'b1;
    @(posedge clk);
    #1 cmd_valid_a = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_cmd_ready", cmd_ready_a, 0);
    check("mid_rst_ram_write", ram_write_a, 0);
    check("mid_rst_ram_addr", ram_addr_a, 0);
    check("mid_rst_ram_data", ram_data_a, 0);
    check("mid_rst_busy", busy_a, 1);
    check("mid_rst_in_line", in_line_a, 0);
    check("mid_rst_error", error_a, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_init_write", {ram_write_a, ram_addr_a, ram_data_a}, {1'b1, 9'd0, 8'd0});
    @(negedge clk);
    check("mid_rst_idle", cmd_ready_a, 1);

    repeat (2) @(negedge clk);
    check("queue_a_empty", exp_a_q.size(), 0);
    check("queue_b_empty", exp_b_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
